// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the write-posting store buffer.
// Module parameters default to these values and are expected to match them.
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;
   localparam int PTR_W    = $clog2(SB_DEPTH);
   localparam int CNT_W    = PTR_W + 1;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

   // Word-granular address: byte offset bits are irrelevant to matching.
   function automatic logic [SB_AW-3:0] word_index(input logic [SB_AW-1:0] addr);
      return addr[SB_AW-1:2];
   endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the buffered stores for load forwarding.
// Purely combinational; only entries inside [rd_ptr, rd_ptr+count) are considered.
module sb_fwd_match
   import store_buffer_pkg::*;
(
   input  sb_entry_t          entries [SB_DEPTH],
   input  logic [PTR_W-1:0]   rd_ptr,
   input  logic [CNT_W-1:0]   count,
   input  logic [SB_AW-1:0]   query,
   output logic               hit,
   output logic [SB_DW-1:0]   data
);

   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise the
      // no-match path would infer a latch.
      hit  = 1'b0;
      data = '0;
      // Walk oldest to youngest so the last match found is the youngest.
      for (int i = 0; i < SB_DEPTH; i++) begin
         if ((CNT_W'(i) < count) &&
             (word_index(entries[PTR_W'(rd_ptr + PTR_W'(i))].addr) == word_index(query))) begin
            hit  = 1'b1;
            data = entries[PTR_W'(rd_ptr + PTR_W'(i))].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Write-posting store buffer: captures core stores in a circular FIFO, drains
// them over a req/ack handshake and forwards buffered data to loads.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWr,
   input  logic             MemRead,
   input  logic [AW-1:0]    address,
   input  logic [DW-1:0]    data_in,
   output logic [DW-1:0]    data_out,
   output logic             stall,
   output logic             mem_req,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic             mem_ack,
   input  logic [DW-1:0]    mem_rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   sb_entry_t        entries [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             enq;
   logic             deq;
   logic             fwd_hit;
   logic [DW-1:0]    fwd_data;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign mem_req = ~empty;

   // A drain on the same edge frees the slot the blocked store needs.
   assign deq   = mem_req & mem_ack;
   assign stall = MemWr & full & ~deq;
   assign enq   = MemWr & ~stall;

   assign mem_addr  = entries[rd_ptr].addr;
   assign mem_wdata = entries[rd_ptr].data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: the storage is reset on purpose so mem_addr/mem_wdata read 0
         // after reset; a RAM macro could not be used for it.
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values of enq/deq and the pointers.
         if (enq) begin
            entries[wr_ptr] <= '{addr: address, data: data_in};
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (enq && !deq) begin
            count <= count + 1'b1;
         end else if (!enq && deq) begin
            count <= count - 1'b1;
         end
      end
   end

   sb_fwd_match u_fwd (
      .entries (entries),
      .rd_ptr  (rd_ptr),
      .count   (count),
      .query   (address),
      .hit     (fwd_hit),
      .data    (fwd_data)
   );

   assign data_out = (MemRead && fwd_hit) ? fwd_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: table-driven cycles, a drain
// scoreboard, a random-ack wrap-around run and an asynchronous reset.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWr, MemRead, mem_ack;
   logic [31:0] address, data_in, mem_rdata;
   logic [31:0] data_out, mem_addr, mem_wdata;
   logic        stall, mem_req, full, empty;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } drain_t;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        exp_stall;
      logic [31:0] exp_dout;
      int          exp_count;
   } vec_t;

   drain_t sb_q[$];
   vec_t   vecs[$];

   store_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .MemWr     (MemWr),
      .MemRead   (MemRead),
      .address   (address),
      .data_in   (data_in),
      .data_out  (data_out),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory side: every accepted write must match the oldest expected store.
   always @(posedge clk) begin
      if (!reset && mem_req && mem_ack) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_unexpected: got addr %h data %h expected no write", mem_addr, mem_wdata);
         end else begin
            drain_t e;
            e = sb_q.pop_front();
            check("drain_addr", {32'b0, mem_addr}, {32'b0, e.addr});
            check("drain_data", {32'b0, mem_wdata}, {32'b0, e.data});
         end
      end
   end

   function automatic vec_t mk(logic wr, logic rd, logic [31:0] addr, logic [31:0] wdata,
                               logic ack, logic [31:0] rdata, logic exp_stall,
                               logic [31:0] exp_dout, int exp_count);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.ack = ack;
      v.rdata = rdata; v.exp_stall = exp_stall; v.exp_dout = exp_dout; v.exp_count = exp_count;
      return v;
   endfunction

   task automatic check_status(input string tag, input int exp_count);
      check({tag, "_count"}, {61'b0, count}, 64'(exp_count));
      check({tag, "_full"},  {63'b0, full},  {63'b0, (exp_count == 4)});
      check({tag, "_empty"}, {63'b0, empty}, {63'b0, (exp_count == 0)});
      check({tag, "_req"},   {63'b0, mem_req}, {63'b0, (exp_count != 0)});
   endtask

   // Entered at posedge+1; leaves at the following posedge+1.
   task automatic apply(input vec_t v, input int idx);
      MemWr = v.wr; MemRead = v.rd; address = v.addr; data_in = v.wdata;
      mem_ack = v.ack; mem_rdata = v.rdata;
      if (v.wr && !v.exp_stall) sb_q.push_back('{addr: v.addr, data: v.wdata});
      #2;
      check($sformatf("v%0d_stall", idx), {63'b0, stall}, {63'b0, v.exp_stall});
      check($sformatf("v%0d_dout", idx), {32'b0, data_out}, {32'b0, v.exp_dout});
      @(posedge clk);
      #1;
      check_status($sformatf("v%0d", idx), v.exp_count);
   endtask

   initial begin
      int mcount;
      int issued;
      int cycles;
      logic exp_stall;

      reset = 1'b1; MemWr = 0; MemRead = 0; mem_ack = 0;
      address = '0; data_in = '0; mem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_status("rst", 0);
      check("rst_addr",  {32'b0, mem_addr},  64'h0);
      check("rst_wdata", {32'b0, mem_wdata}, 64'h0);
      check("rst_dout",  {32'b0, data_out},  64'hDEAD_BEEF);

      //            wr rd addr   wdata  ack rdata         stl dout          cnt
      vecs.push_back(mk(0, 0, 32'h00, 32'h0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk(1, 0, 32'h10, 32'h1, 0, 32'h0,   0, 32'h0,   1));
      vecs.push_back(mk(1, 0, 32'h14, 32'h2, 0, 32'h0,   0, 32'h0,   2));
      vecs.push_back(mk(1, 0, 32'h18, 32'h3, 0, 32'h0,   0, 32'h0,   3));
      vecs.push_back(mk(1, 0, 32'h1C, 32'h4, 0, 32'h0,   0, 32'h0,   4));
      vecs.push_back(mk(1, 0, 32'h30, 32'h55, 0, 32'h0,  1, 32'h0,   4));
      vecs.push_back(mk(0, 1, 32'h14, 32'h0, 0, 32'h0,   0, 32'h2,   4));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   3));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   2));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   0));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   0));
      // full + store + ack: accepted into the freed slot, drains fifth
      vecs.push_back(mk(1, 0, 32'h40, 32'h11, 0, 32'h0,  0, 32'h0,   1));
      vecs.push_back(mk(1, 0, 32'h44, 32'h12, 0, 32'h0,  0, 32'h0,   2));
      vecs.push_back(mk(1, 0, 32'h48, 32'h13, 0, 32'h0,  0, 32'h0,   3));
      vecs.push_back(mk(1, 0, 32'h4C, 32'h14, 0, 32'h0,  0, 32'h0,   4));
      vecs.push_back(mk(1, 0, 32'h50, 32'h15, 1, 32'h0,  0, 32'h0,   4));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   3));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   2));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   0));
      // forwarding: youngest match, low bits ignored, miss passes mem_rdata
      vecs.push_back(mk(1, 0, 32'h20, 32'h5, 0, 32'h0,   0, 32'h0,   1));
      vecs.push_back(mk(1, 0, 32'h20, 32'h9, 0, 32'h0,   0, 32'h0,   2));
      vecs.push_back(mk(0, 1, 32'h20, 32'h0, 0, 32'h0,   0, 32'h9,   2));
      vecs.push_back(mk(0, 1, 32'h22, 32'h0, 0, 32'h0,   0, 32'h9,   2));
      vecs.push_back(mk(0, 1, 32'h24, 32'h0, 0, 32'h77,  0, 32'h77,  2));
      vecs.push_back(mk(0, 1, 32'h20, 32'h0, 1, 32'h0,   0, 32'h9,   1));
      vecs.push_back(mk(0, 1, 32'h20, 32'h0, 0, 32'h0,   0, 32'h9,   1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   0));
      vecs.push_back(mk(0, 1, 32'h20, 32'h0, 0, 32'h123, 0, 32'h123, 0));
      // a store is not forwardable in the cycle it is presented
      vecs.push_back(mk(1, 1, 32'h60, 32'hAB, 0, 32'hCC, 0, 32'hCC,  1));
      vecs.push_back(mk(0, 1, 32'h60, 32'h0, 0, 32'hCC,  0, 32'hAB,  1));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0, 1, 32'h0,   0, 32'h0,   0));

      foreach (vecs[i]) apply(vecs[i], i);

      // Wrap-around with random ack; repeated addresses check program order.
      mcount = 0; issued = 0; cycles = 0;
      while ((issued < 10 || mcount != 0) && cycles < 200) begin
         MemWr   = (issued < 10);
         MemRead = 1'b0;
         address = 32'h100 + 32'(4 * (issued % 3));
         data_in = 32'h1000 + 32'(issued);
         mem_ack = (issued < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
         exp_stall = MemWr && (mcount == 4) && !mem_ack;
         if (MemWr && !exp_stall) sb_q.push_back('{addr: address, data: data_in});
         #2;
         check("wrap_stall", {63'b0, stall}, {63'b0, exp_stall});
         @(posedge clk);
         #1;
         mcount = mcount + ((MemWr && !exp_stall) ? 1 : 0) - ((mem_ack && mcount > 0) ? 1 : 0);
         if (MemWr && !exp_stall) issued++;
         check("wrap_count", {61'b0, count}, 64'(mcount));
         if (count > 3'd4) check("wrap_overflow", {61'b0, count}, 64'd4);
         cycles++;
      end
      check("wrap_done", 64'(cycles < 200), 64'd1);
      MemWr = 0; mem_ack = 0;

      // Asynchronous reset with three stores pending.
      apply(mk(1, 0, 32'h300, 32'h31, 0, 32'h0, 0, 32'h0, 1), 100);
      apply(mk(1, 0, 32'h304, 32'h32, 0, 32'h0, 0, 32'h0, 2), 101);
      apply(mk(1, 0, 32'h308, 32'h33, 0, 32'h0, 0, 32'h0, 3), 102);
      MemWr = 0;
      #2 reset = 1'b1;
      #1;
      check_status("arst", 0);
      check("arst_addr",  {32'b0, mem_addr},  64'h0);
      check("arst_wdata", {32'b0, mem_wdata}, 64'h0);
      sb_q.delete();
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      apply(mk(1, 0, 32'h200, 32'hA, 0, 32'h0, 0, 32'h0, 1), 103);
      check("post_rst_head", {32'b0, mem_addr}, 64'h200);
      apply(mk(1, 0, 32'h204, 32'hB, 0, 32'h0, 0, 32'h0, 2), 104);
      apply(mk(0, 0, 32'h0, 32'h0, 1, 32'h0, 0, 32'h0, 1), 105);
      apply(mk(0, 0, 32'h0, 32'h0, 1, 32'h0, 0, 32'h0, 0), 106);
      mem_ack = 0;

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
